work_dispatcher: RTL and testbench
==================================

// Module: work_dispatcher
// PURPOSE
//  Work-queue dispatcher feeding PCs to NUM_CORES processor cores; it sits directly upstream of each core.
//  - Accepts "enqueue queue N" pulses (queue_wen/queue_number) from the cores.
//  - Buffers them in a FIFO.
//  - When a core raises request_new_pc, it pops the FIFO head and translates the queue number
//    to an entry PC through a programmable table.
//  - Detects global termination: FIFO empty, no pending enqueues, and every core waiting.
// PARAMETERS
//  NUM_CORES   2    cores served, >=1
//  FIFO_DEPTH  16   pending-work entries, power of two
//  PC_W        16   program-counter width
//  QN_W        4    queue-number width; the entry table has 2**QN_W entries
// PORTS
//  clk           in   1               clock, all state rises on posedge
//  rst_n         in   1               async active-low reset
//  cfg_wen       in   1               write entry_pc[cfg_addr] <= cfg_pc
//  cfg_addr      in   QN_W            entry table address
//  cfg_pc        in   PC_W            entry PC value
//  start         in   1               kick-off pulse; pushes start_queue and wakes all cores
//  start_queue   in   QN_W            first queue to run
//  queue_wen     in   NUM_CORES       per-core enqueue pulse (1 cycle)
//  queue_number  in   NUM_CORES*QN_W  per-core queue number; core i uses slice i
//  request_new_pc in  NUM_CORES       per-core "need work" level
//  new_pc        out  NUM_CORES*PC_W  per-core granted PC; held stable between grants
//  idle          out  NUM_CORES*2     per-core: 00 BUSY, 01 WAIT (stall), 10 DONE (stall)
//  all_done      out  1               set on termination; cleared by an accepted start
//  overflow      out  1               sticky, set when an enqueue is dropped
// BEHAVIOUR
//  Reset values:
//  - All cores DONE (idle=10), new_pc=0.
//  - all_done=0, overflow=0; FIFO, skids and round-robin pointers cleared.
//  - Entry table reset to 0.
//  Per-core FSM (BUSY/WAIT/DONE):
//  - BUSY & request_new_pc=1 -> WAIT next cycle.
//  - WAIT & granted -> BUSY. In the grant cycle: new_pc_i <= entry_pc[head], FIFO pops.
//    A core's idle reads 00 in the cycle after its grant.
//  - request_new_pc is ignored in WAIT and DONE.
//  - start, accepted only when every core is DONE:
//    all cores -> WAIT, push start_queue, all_done<=0. Ignored otherwise.
//  Enqueue path:
//  - Each core has a 1-entry skid register; queue_wen loads it.
//  - One skid drains into the FIFO per cycle, round-robin starting after the last winner.
//  - start's push has priority over skid drains.
//  - FIFO full: skids hold their contents; nothing is lost.
//  - queue_wen while that core's skid is still occupied: new value dropped, overflow<=1.
//  Pop path:
//  - At most one pop per cycle, round-robin among WAIT cores.
//  - Push and pop in the same cycle are allowed.
//  - No bypass: a pushed entry is visible to pop at the earliest one cycle later.
//  - Minimum latency: WAIT entry -> grant is 1 cycle; work enqueued in cycle t is grantable at t+2.
//  Termination:
//  - Condition: FIFO empty, all skids empty, every core in WAIT, no queue_wen this cycle.
//  - Effect: all cores -> DONE and all_done<=1 next cycle.
//  Entry table:
//  - cfg_wen takes effect the next cycle.
//  - When the written address equals the head, a same-cycle pop uses the old value.
//  Reset mid-operation: reset asserted asynchronously discards all queued work; state returns to reset values.
// STRUCTURE
//  Shared gpu_pkg:
//  - IDLE_BUSY=2'b00, IDLE_WAIT=2'b01, IDLE_DONE=2'b10.
//  - PC_W and QN_W defaults.
//  - Per-core state enum.
//  Sub-module: work_fifo.
//  - Synchronous FIFO with push/pop/full/empty/head; async active-low reset.
//  - Depth FIFO_DEPTH, width QN_W.
//  - Pointers one bit wider than the address so wrap-around is unambiguous.
//  Top level holds: per-core FSMs, skids, two round-robin arbiters, entry table, termination logic.
// TESTING
//  1. Boot:
//     - Stimulus: entry_pc[3]=0x0040; start with start_queue=3.
//     - Required: core0 and core1 go WAIT; one of them gets new_pc=0x0040 and idle=00.
//     - The other remains at idle=01.
//  2. Termination:
//     - Stimulus: the sole BUSY core raises request_new_pc with no enqueues.
//     - Required: both cores idle=10 and all_done=1 within 2 cycles.
//  3. Fan-out:
//     - Stimulus: core0 pulses queue_wen with queue_number=5 (entry 0x0100); core1 is WAIT.
//     - Required: core1 gets new_pc=0x0100 exactly 2 cycles after the pulse.
//  4. Simultaneous enqueue:
//     - Stimulus: both cores pulse queue_wen (queues 1 and 2) in the same cycle.
//     - Required: both entries are pushed in consecutive cycles, no overflow.
//     - Order: round-robin from the pointer.
//  5. Full FIFO:
//     - Stimulus: fill all 16 entries; core0 pulses queue_wen twice while full.
//     - Required: the first value is held in the skid; the second is dropped and overflow=1.
//     - After one pop, the skid entry enters the FIFO.
//  6. Async reset:
//     - Stimulus: assert rst_n=0 with entries queued and cores BUSY.
//     - Required: all cores idle=10 and new_pc=0 immediately; FIFO empty after rst_n=1.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and constants for the work dispatcher: idle encodings, default
// widths and the per-core scheduling state.
package gpu_pkg;

  localparam int DEF_PC_W = 16;
  localparam int DEF_QN_W = 4;

  localparam logic [1:0] IDLE_BUSY = 2'b00;
  localparam logic [1:0] IDLE_WAIT = 2'b01;
  localparam logic [1:0] IDLE_DONE = 2'b10;

  // State values equal the idle codes so the idle port is the state itself.
  typedef enum logic [1:0] {
    CORE_BUSY = IDLE_BUSY,
    CORE_WAIT = IDLE_WAIT,
    CORE_DONE = IDLE_DONE
  } core_state_e;

endpackage

// File: rtl/work_fifo.sv
// Synchronous FIFO of pending queue numbers. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module work_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/work_dispatcher.sv
// Work-queue dispatcher: per-core BUSY/WAIT/DONE schedulers, enqueue skids,
// round-robin push and pop arbitration, entry-PC table and termination detect.
module work_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int PC_W       = DEF_PC_W,
  parameter int QN_W       = DEF_QN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wen,
  input  logic [QN_W-1:0]           cfg_addr,
  input  logic [PC_W-1:0]           cfg_pc,
  input  logic                      start,
  input  logic [QN_W-1:0]           start_queue,
  input  logic [NUM_CORES-1:0]      queue_wen,
  input  logic [NUM_CORES*QN_W-1:0] queue_number,
  input  logic [NUM_CORES-1:0]      request_new_pc,
  output logic [NUM_CORES*PC_W-1:0] new_pc,
  output logic [NUM_CORES*2-1:0]    idle,
  output logic                      all_done,
  output logic                      overflow
);

  localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TBL = 2 ** QN_W;

  core_state_e                         state_q [NUM_CORES];
  logic [NUM_CORES-1:0][PC_W-1:0]      new_pc_q;
  logic [NUM_CORES-1:0]                skid_vld_q;
  logic [NUM_CORES-1:0][QN_W-1:0]      skid_qn_q;
  logic [NUM_CORES-1:0][QN_W-1:0]      qn_in;
  logic [PC_W-1:0]                     entry_pc_q [TBL];
  logic [CW-1:0]                       rr_push_q, rr_pop_q;
  logic                                all_done_q, overflow_q;

  logic                 all_cores_done, start_acc, term;
  logic [NUM_CORES-1:0] wait_vec;
  logic                 pop_found, pop_en, drn_found, drain_en, push_en;
  logic [CW-1:0]        pop_idx, drn_idx;
  logic [QN_W-1:0]      push_qn, fifo_head;
  logic                 fifo_full, fifo_empty;

  // Returns {found, index}: first requester strictly after 'last', wrapping.
  function automatic logic [CW:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                          input logic [CW-1:0] last);
    logic          found;
    logic [CW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (!found && req[i] && i > int'(last)) begin
        found = 1'b1;
        win   = CW'(i);
      end
    for (int i = 0; i < NUM_CORES; i++)
      if (!found && req[i]) begin
        found = 1'b1;
        win   = CW'(i);
      end
    return {found, win};
  endfunction

  // NOTE: every always_comb output is given a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    all_cores_done = 1'b1;
    wait_vec       = '0;
    idle           = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (state_q[i] != CORE_DONE) all_cores_done = 1'b0;
      wait_vec[i]      = (state_q[i] == CORE_WAIT);
      idle[2*i +: 2]   = state_q[i];
    end
  end

  assign qn_in                = queue_number;
  assign {pop_found, pop_idx} = rr_pick(wait_vec, rr_pop_q);
  assign {drn_found, drn_idx} = rr_pick(skid_vld_q, rr_push_q);
  assign start_acc = start && all_cores_done;
  assign pop_en    = pop_found && !fifo_empty;
  // The start push wins the single FIFO write port over skid drains.
  assign drain_en  = drn_found && !fifo_full && !start_acc;
  assign push_en   = start_acc || drain_en;
  assign push_qn   = start_acc ? start_queue : skid_qn_q[drn_idx];
  assign term      = fifo_empty && !(|skid_vld_q) && (&wait_vec) && !(|queue_wen);

  work_fifo #(.DEPTH(FIFO_DEPTH), .W(QN_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_en),
    .push_data_i (push_qn),
    .pop_i       (pop_en),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= CORE_DONE;
      new_pc_q   <= '0;
      all_done_q <= 1'b0;
      rr_pop_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        case (state_q[i])
          CORE_BUSY: if (request_new_pc[i]) state_q[i] <= CORE_WAIT;
          CORE_WAIT: begin
            if (term) begin
              state_q[i] <= CORE_DONE;
            end else if (pop_en && pop_idx == CW'(i)) begin
              state_q[i]  <= CORE_BUSY;
              new_pc_q[i] <= entry_pc_q[fifo_head];
            end
          end
          CORE_DONE: if (start_acc) state_q[i] <= CORE_WAIT;
          default:   state_q[i] <= CORE_DONE;
        endcase
      end
      if (start_acc)  all_done_q <= 1'b0;
      else if (term)  all_done_q <= 1'b1;
      if (pop_en)     rr_pop_q   <= pop_idx;
    end
  end

  // A skid that drains this cycle is free to take a new enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q <= '0;
      skid_qn_q  <= '0;
      overflow_q <= 1'b0;
      rr_push_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (queue_wen[i]) begin
          if (!skid_vld_q[i] || (drain_en && drn_idx == CW'(i))) begin
            skid_vld_q[i] <= 1'b1;
            skid_qn_q[i]  <= qn_in[i];
          end else begin
            overflow_q <= 1'b1;
          end
        end else if (drain_en && drn_idx == CW'(i)) begin
          skid_vld_q[i] <= 1'b0;
        end
      end
      if (drain_en) rr_push_q <= drn_idx;
    end
  end

  // The entry table has defined contents out of reset, unlike the FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < TBL; a++) entry_pc_q[a] <= '0;
    end else if (cfg_wen) begin
      entry_pc_q[cfg_addr] <= cfg_pc;
    end
  end

  assign new_pc   = new_pc_q;
  assign all_done = all_done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: boot, termination, fan-out, simultaneous
// enqueue, full-FIFO overflow and asynchronous reset.
module tb_work_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_wen;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_pc;
  logic        start;
  logic [3:0]  start_queue;
  logic [1:0]  queue_wen;
  logic [7:0]  queue_number;
  logic [1:0]  request_new_pc;
  logic [31:0] new_pc;
  logic [3:0]  idle;
  logic        all_done;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  work_dispatcher #(.NUM_CORES(2), .FIFO_DEPTH(16), .PC_W(16), .QN_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wen        (cfg_wen),
    .cfg_addr       (cfg_addr),
    .cfg_pc         (cfg_pc),
    .start          (start),
    .start_queue    (start_queue),
    .queue_wen      (queue_wen),
    .queue_number   (queue_number),
    .request_new_pc (request_new_pc),
    .new_pc         (new_pc),
    .idle           (idle),
    .all_done       (all_done),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] a, input logic [15:0] pc);
    cfg_wen  = 1'b1;
    cfg_addr = a;
    cfg_pc   = pc;
    step();
    cfg_wen  = 1'b0;
  endtask

  function automatic logic [1:0] idle_of(input int c);
    return (c == 0) ? idle[1:0] : idle[3:2];
  endfunction

  function automatic logic [15:0] pc_of(input int c);
    return (c == 0) ? new_pc[15:0] : new_pc[31:16];
  endfunction

  function automatic logic [1:0] onehot(input int c);
    return (c == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [7:0] qn_for(input int c, input logic [3:0] q);
    return (c == 0) ? {4'h0, q} : {q, 4'h0};
  endfunction

  task automatic do_start(input logic [3:0] q);
    start       = 1'b1;
    start_queue = q;
    step();
    start       = 1'b0;
  endtask

  initial begin
    int g, w, p, grants, n77;
    logic [15:0] last_pc, first_pc, second_pc;
    logic [1:0]  prev0, prev1;
    bit          finished;

    rst_n = 1'b0; cfg_wen = 1'b0; cfg_addr = '0; cfg_pc = '0;
    start = 1'b0; start_queue = '0; queue_wen = '0; queue_number = '0;
    request_new_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    check("reset_idle",     32'(idle),     32'hA);
    check("reset_new_pc",   new_pc,        32'h0);
    check("reset_all_done", 32'(all_done), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);

    cfg(4'd3, 16'h0040); cfg(4'd5, 16'h0100); cfg(4'd1, 16'h0011);
    cfg(4'd2, 16'h0022); cfg(4'd7, 16'h0077); cfg(4'd9, 16'h0099);
    cfg(4'd10, 16'h00AA);

    // Boot: both cores wake; the grant edge also rewrites entry 3.
    do_start(4'd3);
    check("boot_all_wait", 32'(idle), 32'h5);
    cfg(4'd3, 16'h0999);
    g = (idle_of(0) == 2'b00) ? 0 : 1;
    w = 1 - g;
    check("boot_granted_busy", 32'(idle_of(g)), 32'h0);
    check("boot_other_wait",   32'(idle_of(w)), 32'h1);
    check("boot_pc_old_entry", 32'(pc_of(g)),   32'h40);
    step();
    check("boot_other_still_wait", 32'(idle_of(w)), 32'h1);

    // Termination.
    request_new_pc = onehot(g);
    step();
    request_new_pc = '0;
    check("term_both_wait",   32'(idle),     32'h5);
    check("term_not_yet",     32'(all_done), 32'h0);
    step();
    check("term_all_done_idle", 32'(idle),     32'hA);
    check("term_all_done",      32'(all_done), 32'h1);

    // Fan-out: restart sees the rewritten entry 3, then busy core enqueues 5.
    do_start(4'd3);
    check("restart_clears_done", 32'(all_done), 32'h0);
    step();
    g = (idle_of(0) == 2'b00) ? 0 : 1;
    w = 1 - g;
    check("restart_pc_new_entry", 32'(pc_of(g)), 32'h999);
    queue_wen    = onehot(g);
    queue_number = qn_for(g, 4'd5);
    step();
    queue_wen = '0;
    step();
    check("fan_not_early", 32'(idle_of(w)), 32'h1);
    step();
    check("fan_granted",   32'(idle_of(w)), 32'h0);
    check("fan_pc",        32'(pc_of(w)),   32'h100);

    // Simultaneous enqueue: last drain winner was g, so core 1-g drains first.
    first_pc  = (g == 0) ? 16'h0022 : 16'h0011;
    second_pc = (g == 0) ? 16'h0011 : 16'h0022;
    queue_wen      = 2'b11;
    queue_number   = {4'd2, 4'd1};
    request_new_pc = 2'b11;
    step();
    queue_wen = '0;
    request_new_pc = '0;
    check("simul_both_wait", 32'(idle), 32'h5);
    step();
    check("simul_no_bypass", 32'(idle), 32'h5);
    step();
    p = (idle_of(0) == 2'b00) ? 0 : 1;
    check("simul_one_granted", 32'(idle_of(1 - p)), 32'h1);
    check("simul_first_entry", 32'(pc_of(p)),       32'(first_pc));
    step();
    check("simul_second_grant", 32'(idle),           32'h0);
    check("simul_second_entry", 32'(pc_of(1 - p)),   32'(second_pc));
    check("simul_no_overflow",  32'(overflow),       32'h0);

    // Full FIFO: 16 entries of queue 7 from core 1, then core 0 enqueues twice.
    for (int k = 0; k < 16; k++) begin
      queue_wen    = 2'b10;
      queue_number = {4'd7, 4'd0};
      step();
    end
    queue_wen = '0;
    step();
    queue_wen    = 2'b01;
    queue_number = {4'd0, 4'd9};
    step();
    check("full_first_held", 32'(overflow), 32'h0);
    queue_number = {4'd0, 4'd10};
    step();
    queue_wen = '0;
    check("full_second_dropped", 32'(overflow), 32'h1);
    check("full_cores_busy",     32'(idle),     32'h0);

    grants = 0; n77 = 0; last_pc = '0; finished = 1'b0;
    prev0 = idle_of(0); prev1 = idle_of(1);
    request_new_pc = 2'b11;
    for (int k = 0; k < 200 && !finished; k++) begin
      step();
      if (prev0 == 2'b01 && idle_of(0) == 2'b00) begin
        grants++; last_pc = pc_of(0); if (pc_of(0) == 16'h0077) n77++;
      end
      if (prev1 == 2'b01 && idle_of(1) == 2'b00) begin
        grants++; last_pc = pc_of(1); if (pc_of(1) == 16'h0077) n77++;
      end
      prev0 = idle_of(0); prev1 = idle_of(1);
      if (all_done) finished = 1'b1;
    end
    request_new_pc = '0;
    check("drain_terminated",  32'(finished), 32'h1);
    check("drain_grant_count", 32'(grants),   32'd17);
    check("drain_q7_count",    32'(n77),      32'd16);
    check("drain_skid_last",   32'(last_pc),  32'h99);
    check("drain_all_done",    32'(idle),     32'hA);

    // Async reset with work queued and both cores busy.
    do_start(4'd3);
    step();
    g = (idle_of(0) == 2'b00) ? 0 : 1;
    queue_wen    = onehot(g);
    queue_number = qn_for(g, 4'd5);
    repeat (3) step();
    queue_wen = '0;
    check("pre_reset_busy",   32'(idle),     32'h0);
    check("overflow_sticky",  32'(overflow), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_idle",     32'(idle),     32'hA);
    check("areset_new_pc",   new_pc,        32'h0);
    check("areset_overflow", 32'(overflow), 32'h0);
    #3 rst_n = 1'b1;
    step();
    check("post_reset_idle", 32'(idle), 32'hA);
    do_start(4'd3);
    check("post_reset_wait", 32'(idle), 32'h5);
    step();
    g = (idle_of(0) == 2'b00) ? 0 : 1;
    check("post_reset_one_grant", 32'(idle_of(1 - g)), 32'h1);
    check("post_reset_table_zero", 32'(pc_of(g)),      32'h0);
    step();
    check("post_reset_fifo_empty", 32'(idle_of(1 - g)), 32'h1);
    request_new_pc = onehot(g);
    step();
    request_new_pc = '0;
    step();
    check("post_reset_term", 32'(all_done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
